// File: rtl/hnf_txreq_issue_pkg.sv
// Shared CHI request-channel definitions for the HN-F TXREQ issue stage.
//  reqflit_t      : packed REQ flit (subset of fields used by this stage)
//  OP_*           : request opcodes used here
//  txreq_state_t  : TXREQ link-control state
package hnf_txreq_issue_pkg;

  // Width of SrcID/TgtID node-ID fields.
  localparam int CHI_SRCID_RANGE = 7;

  localparam logic [5:0] OP_ReqLCrdReturn = 6'h00;
  localparam logic [5:0] OP_ReadNoSnp     = 6'h04;

  typedef struct packed {
    logic [3:0]                 qos;
    logic [CHI_SRCID_RANGE-1:0] tgtid;
    logic [CHI_SRCID_RANGE-1:0] srcid;
    logic [7:0]                 txnid;
    logic [5:0]                 opcode;
    logic [2:0]                 size;
    logic [47:0]                addr;
  } reqflit_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    RETURN = 2'd2,
    STOP   = 2'd3
  } txreq_state_t;

endpackage

// File: rtl/hnf_txreq_issue_fifo.sv
// Synchronous FIFO holding queued ReadNoSnp flits.
//  clk_i/rst_i : clock, synchronous active-high reset (flushes pointers/count)
//  push_i      : write wdata_i at the tail (ignored when full)
//  pop_i       : advance the head (ignored when empty)
//  rdata_o     : current head entry (combinational read)
//  full_o/empty_o/count_o : occupancy; count is $clog2(DEPTH)+1 bits
module hnf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap without extra logic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hnf_txreq_issue.sv
// HN-F TXREQ issue stage: queues ReadNoSnp flits from the lookup stage and sends
// them to the SN-F under L-credit flow control, stamping TgtID=SN_NID. A link-stop
// request drains the queue, returns unused credits with ReqLCrdReturn, then stops.
//  clock_i, reset_i        : clock, synchronous active-high reset
//  read_no_snp_i/_v_i      : incoming flit + valid (source cannot be stalled)
//  rns_ready_o             : queue can accept next cycle's flit (registered)
//  txreqflitpend_o         : early flit-pending indication
//  txreqflitv_o/txreqflit_o: TXREQ flit valid pulse and flit
//  txreq_lcrdv_i           : L-credit grant pulse
//  link_stop_req_i         : level request to deactivate TXREQ
//  link_stopped_o          : credits returned, link idle
//  overflow_err_o          : sticky, flit dropped
//  credit_err_o            : sticky, credit overflow or credit while stopped
//  dbg_state_o/dbg_lcrd_cnt_o : FSM state and credit count for observation
module hnf_txreq_issue
  import hnf_txreq_issue_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         MAX_LCRD = 15,
  parameter logic [6:0] SN_NID   = 7'd0,
  parameter logic [6:0] HN_NID   = 7'd0
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  reqflit_t                        read_no_snp_i,
  input  logic                            read_no_snp_v_i,
  output logic                            rns_ready_o,
  output logic                            txreqflitpend_o,
  output logic                            txreqflitv_o,
  output reqflit_t                        txreqflit_o,
  input  logic                            txreq_lcrdv_i,
  input  logic                            link_stop_req_i,
  output logic                            link_stopped_o,
  output logic                            overflow_err_o,
  output logic                            credit_err_o,
  output logic [1:0]                      dbg_state_o,
  output logic [$clog2(MAX_LCRD+1)-1:0]   dbg_lcrd_cnt_o
);

  localparam int CW = $clog2(MAX_LCRD+1);
  localparam int QW = $clog2(DEPTH)+1;

  txreq_state_t  state_q, state_d;
  logic [CW-1:0] lcrd_cnt_q, lcrd_cnt_d;
  logic [QW-1:0] count, count_d;
  logic          full, empty;
  reqflit_t      head, issue_flit, ret_flit, txreqflit_q;
  logic          rns_ready_q, pend_q, flitv_q, stopped_q, ovf_err_q, crd_err_q;
  logic          push, drop, can_issue, send_ret, dec, lcrd_take, cred_ovf;

  // Handshake: the source offers a flit with read_no_snp_v_i and never waits.
  // The flit is taken when rns_ready_o was 1 in that cycle; otherwise it is lost
  // and overflow_err_o latches. rns_ready_o already reflects this cycle's pop.
  assign push = read_no_snp_v_i && rns_ready_q && !full;
  assign drop = read_no_snp_v_i && !push;

  hnf_sync_fifo #(.WIDTH($bits(reqflit_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .push_i  (push),
    .pop_i   (can_issue),
    .wdata_i (read_no_snp_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign can_issue = !empty && (lcrd_cnt_q != '0) && (state_q == RUN || state_q == DRAIN);
  assign send_ret  = (state_q == RETURN) && (lcrd_cnt_q != '0);
  assign dec       = can_issue || send_ret;
  // Credits arriving once stopped are protocol errors and are not banked.
  assign lcrd_take = txreq_lcrdv_i && (state_q != STOP);

  always_comb begin
    issue_flit       = head;
    issue_flit.tgtid = SN_NID;
    ret_flit         = '0;
    ret_flit.opcode  = OP_ReqLCrdReturn;
    ret_flit.srcid   = HN_NID;
    ret_flit.tgtid   = SN_NID;
  end

  always_comb begin
    lcrd_cnt_d = lcrd_cnt_q;
    cred_ovf   = 1'b0;
    if (lcrd_take && !dec) begin
      if (lcrd_cnt_q == CW'(MAX_LCRD)) cred_ovf = 1'b1;
      else                              lcrd_cnt_d = lcrd_cnt_q + CW'(1);
    end else if (!lcrd_take && dec) begin
      lcrd_cnt_d = lcrd_cnt_q - CW'(1);
    end
  end

  always_comb begin
    case ({push, can_issue})
      2'b10:   count_d = count + QW'(1);
      2'b01:   count_d = count - QW'(1);
      default: count_d = count;
    endcase
  end

  // A stop request that drops mid-sequence still completes to STOP first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:    if (link_stop_req_i) state_d = DRAIN;
      DRAIN:  if (empty) state_d = RETURN;
      RETURN: if (lcrd_cnt_q == '0 && !txreq_lcrdv_i) state_d = STOP;
      STOP:   if (!link_stop_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Status outputs are registered from next-state values so they line up with
  // the state the link is entering.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      lcrd_cnt_q  <= '0;
      txreqflit_q <= '0;
      flitv_q     <= 1'b0;
      rns_ready_q <= 1'b0;
      pend_q      <= 1'b0;
      stopped_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      crd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lcrd_cnt_q <= lcrd_cnt_d;
      flitv_q    <= dec;
      if (can_issue)     txreqflit_q <= issue_flit;
      else if (send_ret) txreqflit_q <= ret_flit;
      rns_ready_q <= (count_d != QW'(DEPTH)) && (state_d == RUN);
      pend_q      <= (count_d != '0) || (state_d == RETURN && lcrd_cnt_d != '0);
      stopped_q   <= (state_d == STOP);
      ovf_err_q   <= ovf_err_q | drop;
      crd_err_q   <= crd_err_q | cred_ovf | (txreq_lcrdv_i && state_q == STOP);
    end
  end

  assign rns_ready_o     = rns_ready_q;
  assign txreqflitpend_o = pend_q;
  assign txreqflitv_o    = flitv_q;
  assign txreqflit_o     = txreqflit_q;
  assign link_stopped_o  = stopped_q;
  assign overflow_err_o  = ovf_err_q;
  assign credit_err_o    = crd_err_q;
  assign dbg_state_o     = state_q;
  assign dbg_lcrd_cnt_o  = lcrd_cnt_q;

endmodule

// File: tb/tb_hnf_txreq_issue.sv
module tb_hnf_txreq_issue;
  import hnf_txreq_issue_pkg::*;

  localparam logic [6:0] SN = 7'h12;
  localparam logic [6:0] HN = 7'h21;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  reqflit_t   read_no_snp_i = '0;
  logic       read_no_snp_v_i = 1'b0;
  logic       rns_ready_o, txreqflitpend_o, txreqflitv_o;
  reqflit_t   txreqflit_o;
  logic       txreq_lcrdv_i = 1'b0;
  logic       link_stop_req_i = 1'b0;
  logic       link_stopped_o, overflow_err_o, credit_err_o;
  logic [1:0] dbg_state_o;
  logic [3:0] dbg_lcrd_cnt_o;

  int n_total = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  reqflit_t    obs_q[$];
  int          obs_cyc_q[$];
  logic [47:0] exp_q[$];

  hnf_txreq_issue #(.DEPTH(4), .MAX_LCRD(15), .SN_NID(SN), .HN_NID(HN)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .read_no_snp_i   (read_no_snp_i),
    .read_no_snp_v_i (read_no_snp_v_i),
    .rns_ready_o     (rns_ready_o),
    .txreqflitpend_o (txreqflitpend_o),
    .txreqflitv_o    (txreqflitv_o),
    .txreqflit_o     (txreqflit_o),
    .txreq_lcrdv_i   (txreq_lcrdv_i),
    .link_stop_req_i (link_stop_req_i),
    .link_stopped_o  (link_stopped_o),
    .overflow_err_o  (overflow_err_o),
    .credit_err_o    (credit_err_o),
    .dbg_state_o     (dbg_state_o),
    .dbg_lcrd_cnt_o  (dbg_lcrd_cnt_o)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc_cnt <= cyc_cnt + 1;

  // output monitor
  always @(negedge clock_i) begin
    if (txreqflitv_o) begin
      obs_q.push_back(txreqflit_o);
      obs_cyc_q.push_back(cyc_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clock_i);
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic reqflit_t mk_rns(input logic [47:0] a);
    reqflit_t f;
    f        = '0;
    f.opcode = OP_ReadNoSnp;
    f.srcid  = 7'h33;
    f.tgtid  = 7'h55;
    f.txnid  = a[13:6];
    f.size   = 3'd6;
    f.addr   = a;
    return f;
  endfunction

  function automatic reqflit_t exp_rns(input logic [47:0] a);
    reqflit_t f;
    f       = mk_rns(a);
    f.tgtid = SN;
    return f;
  endfunction

  function automatic reqflit_t exp_ret();
    reqflit_t f;
    f        = '0;
    f.opcode = OP_ReqLCrdReturn;
    f.srcid  = HN;
    f.tgtid  = SN;
    return f;
  endfunction

  task automatic chk_zero(input string tag);
    check({tag, "_ready"},   96'(rns_ready_o),     96'(0));
    check({tag, "_pend"},    96'(txreqflitpend_o), 96'(0));
    check({tag, "_flitv"},   96'(txreqflitv_o),    96'(0));
    check({tag, "_flit"},    96'(txreqflit_o),     96'(0));
    check({tag, "_stopped"}, 96'(link_stopped_o),  96'(0));
    check({tag, "_ovf"},     96'(overflow_err_o),  96'(0));
    check({tag, "_crderr"},  96'(credit_err_o),    96'(0));
    check({tag, "_cnt"},     96'(dbg_lcrd_cnt_o),  96'(0));
    check({tag, "_state"},   96'(dbg_state_o),     96'(RUN));
  endtask

  // driver tasks
  task automatic do_reset(input string tag);
    read_no_snp_v_i = 1'b0;
    txreq_lcrdv_i   = 1'b0;
    link_stop_req_i = 1'b0;
    reset_i = 1'b1;
    cyc();
    cyc();
    chk_zero(tag);
    reset_i = 1'b0;
    cyc();
    check({tag, "_ready_after"}, 96'(rns_ready_o), 96'(1));
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic push_flit(input logic [47:0] a);
    read_no_snp_i   = mk_rns(a);
    read_no_snp_v_i = 1'b1;
    cyc();
    read_no_snp_v_i = 1'b0;
  endtask

  task automatic grant(input int n);
    txreq_lcrdv_i = 1'b1;
    repeat (n) cyc();
    txreq_lcrdv_i = 1'b0;
  endtask

  initial begin
    reqflit_t f;
    int got;

    // 1: single flit waits for its first credit
    do_reset("t1_rst");
    push_flit(48'h1000);
    check("t1_pend", 96'(txreqflitpend_o), 96'(1));
    check("t1_noflit0", 96'(txreqflitv_o), 96'(0));
    cyc();
    check("t1_noflit1", 96'(txreqflitv_o), 96'(0));
    grant(1);
    check("t1_noflit2", 96'(txreqflitv_o), 96'(0));
    check("t1_cnt1", 96'(dbg_lcrd_cnt_o), 96'(1));
    cyc();
    check("t1_flitv", 96'(txreqflitv_o), 96'(1));
    check("t1_flit", 96'(txreqflit_o), 96'(exp_rns(48'h1000)));
    check("t1_pend_clr", 96'(txreqflitpend_o), 96'(0));
    check("t1_cnt0", 96'(dbg_lcrd_cnt_o), 96'(0));
    cyc();
    check("t1_pulse", 96'(txreqflitv_o), 96'(0));
    check("t1_hold", 96'(txreqflit_o.addr), 96'(48'h1000));

    // 2: three credits, four back-to-back flits
    do_reset("t2_rst");
    grant(3);
    check("t2_cnt3", 96'(dbg_lcrd_cnt_o), 96'(3));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(48'h2000 + 48'(i * 64));
      push_flit(48'h2000 + 48'(i * 64));
    end
    repeat (4) cyc();
    check("t2_n3", 96'(obs_q.size()), 96'(3));
    if (obs_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        f = obs_q.pop_front();
        check("t2_flit", 96'(f), 96'(exp_rns(exp_q.pop_front())));
      end
      check("t2_b2b1", 96'(obs_cyc_q[1] - obs_cyc_q[0]), 96'(1));
      check("t2_b2b2", 96'(obs_cyc_q[2] - obs_cyc_q[0]), 96'(2));
    end
    check("t2_pend", 96'(txreqflitpend_o), 96'(1));
    check("t2_cnt0", 96'(dbg_lcrd_cnt_o), 96'(0));
    grant(1);
    repeat (2) cyc();
    check("t2_n4", 96'(obs_q.size()), 96'(1));
    if (obs_q.size() == 1) begin
      f = obs_q.pop_front();
      check("t2_flitD", 96'(f), 96'(exp_rns(exp_q.pop_front())));
    end

    // 3: overflow with no credits, then eight credits
    do_reset("t3_rst");
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(48'h3000 + 48'(i * 64));
      push_flit(48'h3000 + 48'(i * 64));
    end
    check("t3_ready0", 96'(rns_ready_o), 96'(0));
    check("t3_ovf", 96'(overflow_err_o), 96'(1));
    check("t3_noflit", 96'(obs_q.size()), 96'(0));
    grant(8);
    repeat (3) cyc();
    check("t3_n4", 96'(obs_q.size()), 96'(4));
    got = obs_q.size();
    for (int i = 0; i < got && i < 4; i++) begin
      f = obs_q.pop_front();
      check("t3_flit", 96'(f), 96'(exp_rns(exp_q.pop_front())));
    end
    check("t3_cnt4", 96'(dbg_lcrd_cnt_o), 96'(4));
    check("t3_ready1", 96'(rns_ready_o), 96'(1));
    check("t3_ovf_sticky", 96'(overflow_err_o), 96'(1));

    // 4: credit in the issue cycle, then saturation
    do_reset("t4_rst");
    grant(1);
    push_flit(48'h4000);
    grant(1);
    check("t4_flitv", 96'(txreqflitv_o), 96'(1));
    check("t4_cnt1", 96'(dbg_lcrd_cnt_o), 96'(1));
    grant(14);
    check("t4_cnt15", 96'(dbg_lcrd_cnt_o), 96'(15));
    check("t4_noerr", 96'(credit_err_o), 96'(0));
    grant(2);
    check("t4_sat", 96'(dbg_lcrd_cnt_o), 96'(15));
    check("t4_crderr", 96'(credit_err_o), 96'(1));

    // 5: link stop with two queued and five credits
    do_reset("t5_rst");
    push_flit(48'h5000);
    push_flit(48'h5040);
    link_stop_req_i = 1'b1;
    cyc();
    check("t5_drain", 96'(dbg_state_o), 96'(DRAIN));
    check("t5_ready0", 96'(rns_ready_o), 96'(0));
    cyc();
    grant(5);
    got = 0;
    for (int i = 0; i < 40 && !link_stopped_o; i++) cyc();
    check("t5_stopped", 96'(link_stopped_o), 96'(1));
    check("t5_stop_state", 96'(dbg_state_o), 96'(STOP));
    cyc();
    check("t5_n5", 96'(obs_q.size()), 96'(5));
    if (obs_q.size() == 5) begin
      check("t5_rns0", 96'(obs_q[0]), 96'(exp_rns(48'h5000)));
      check("t5_rns1", 96'(obs_q[1]), 96'(exp_rns(48'h5040)));
      for (int i = 2; i < 5; i++) check("t5_ret", 96'(obs_q[i]), 96'(exp_ret()));
    end
    check("t5_cnt0", 96'(dbg_lcrd_cnt_o), 96'(0));
    check("t5_noerr", 96'(credit_err_o), 96'(0));
    check("t5_pend0", 96'(txreqflitpend_o), 96'(0));
    link_stop_req_i = 1'b0;
    cyc();
    check("t5_run", 96'(dbg_state_o), 96'(RUN));
    check("t5_unstopped", 96'(link_stopped_o), 96'(0));
    check("t5_ready1", 96'(rns_ready_o), 96'(1));

    // 6: reset during DRAIN
    do_reset("t6_rst");
    push_flit(48'h6000);
    push_flit(48'h6040);
    link_stop_req_i = 1'b1;
    cyc();
    cyc();
    check("t6_drain", 96'(dbg_state_o), 96'(DRAIN));
    reset_i = 1'b1;
    cyc();
    chk_zero("t6_mid");
    reset_i = 1'b0;
    link_stop_req_i = 1'b0;
    cyc();
    obs_q.delete();
    push_flit(48'h6080);
    repeat (4) cyc();
    check("t6_needcrd", 96'(obs_q.size()), 96'(0));
    check("t6_pend", 96'(txreqflitpend_o), 96'(1));
    grant(1);
    repeat (2) cyc();
    check("t6_n1", 96'(obs_q.size()), 96'(1));
    if (obs_q.size() == 1) check("t6_flit", 96'(obs_q[0]), 96'(exp_rns(48'h6080)));
    check("t6_pend0", 96'(txreqflitpend_o), 96'(0));

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
